// File: rtl/jtcps2_irqctl.sv
// CPS2 interrupt and raster-register controller: 68000 register decode, raster
// counter access strobes, VB/raster pending flags and IPL priority encoding.
module jtcps2_irqctl #(
  parameter logic [2:0] VB_LEVEL = 3'd2,
  parameter logic [2:0] RS_LEVEL = 3'd4
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic        vb_start,
  input  logic        raster,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic        wrn,
  input  logic [15:0] cpu_dout,
  input  logic [8:0]  cnt_dout,
  output logic [15:0] cpu_din,
  output logic        ok,
  output logic [2:0]  cnt_sel,
  output logic        cnt_wrn,
  input  logic        iack,
  input  logic [2:0]  iack_lvl,
  output logic [2:0]  ipln
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state;
  logic        acc_cnt;
  logic [2:0]  addr_l;
  logic        wrn_l;
  logic        vb_en, rs_en;
  logic        vb_pend, rs_pend;
  logic        raster_d, iack_d;

  logic        acc_end, wr_end, ctrl_wr, stat_wr;
  logic        rise, ack;
  logic        vb_nxt, rs_nxt;
  logic [15:0] rd_data;
  logic [2:0]  lvl;

  // Event logic runs on every clk, so the pixel enable and upper data bits are not needed.
  logic unused;
  assign unused = &{1'b0, pxl_cen, cpu_dout[15:2]};

  always_comb begin
    acc_end = (state == ACC) && acc_cnt;
    wr_end  = acc_end && !wrn_l;
    ctrl_wr = wr_end && (addr_l == 3'd3);
    stat_wr = wr_end && (addr_l == 3'd4);
    rise    = raster & ~raster_d;
    ack     = iack & ~iack_d;

    // Clears first, then a same-cycle event re-sets; disabling an enable always wins.
    rs_nxt = rs_pend;
    if ((ack && iack_lvl == RS_LEVEL) || (stat_wr && cpu_dout[1])) rs_nxt = 1'b0;
    if (rise && rs_en) rs_nxt = 1'b1;
    if (ctrl_wr && !cpu_dout[1]) rs_nxt = 1'b0;

    vb_nxt = vb_pend;
    if ((ack && iack_lvl == VB_LEVEL) || (stat_wr && cpu_dout[0])) vb_nxt = 1'b0;
    if (vb_start && vb_en) vb_nxt = 1'b1;
    if (ctrl_wr && !cpu_dout[0]) vb_nxt = 1'b0;

    rd_data = '0;
    case (addr_l)
      3'd0, 3'd1, 3'd2: rd_data = {7'd0, cnt_dout};
      3'd3:             rd_data = {14'd0, rs_en, vb_en};
      3'd4:             rd_data = {14'd0, rs_pend, vb_pend};
      default:          rd_data = '0;
    endcase

    if (rs_pend)      lvl = RS_LEVEL;
    else if (vb_pend) lvl = VB_LEVEL;
    else              lvl = 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc_cnt <= 1'b0;
      addr_l  <= '0;
      wrn_l   <= 1'b1;
      cpu_din <= '0;
      ok      <= 1'b0;
      cnt_sel <= '0;
      cnt_wrn <= 1'b1;
    end else begin
      ok <= 1'b0;
      case (state)
        IDLE: if (cs) begin
          state   <= ACC;
          acc_cnt <= 1'b0;
          addr_l  <= addr;
          wrn_l   <= wrn;
          case (addr)
            3'd0:    begin cnt_sel <= 3'b001; cnt_wrn <= wrn; end
            3'd1:    begin cnt_sel <= 3'b010; cnt_wrn <= wrn; end
            3'd2:    begin cnt_sel <= 3'b100; cnt_wrn <= wrn; end
            default: begin cnt_sel <= '0;     cnt_wrn <= 1'b1; end
          endcase
        end
        ACC: begin
          if (acc_cnt) begin
            state   <= DONE;
            cpu_din <= rd_data;
            ok      <= 1'b1;
            cnt_sel <= '0;
            cnt_wrn <= 1'b1;
          end
          acc_cnt <= 1'b1;
        end
        DONE: if (!cs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_en    <= 1'b0;
      rs_en    <= 1'b0;
      vb_pend  <= 1'b0;
      rs_pend  <= 1'b0;
      raster_d <= 1'b0;
      iack_d   <= 1'b0;
      ipln     <= 3'b111;
    end else begin
      raster_d <= raster;
      iack_d   <= iack;
      vb_pend  <= vb_nxt;
      rs_pend  <= rs_nxt;
      if (ctrl_wr) begin
        vb_en <= cpu_dout[0];
        rs_en <= cpu_dout[1];
      end
      ipln <= ~lvl;
    end
  end

endmodule

// File: tb/tb_jtcps2_irqctl.sv
// Directed self-checking bench for jtcps2_irqctl.
module tb_jtcps2_irqctl;

  logic        rst, clk, pxl_cen, vb_start, raster, cs, wrn, iack, ok, cnt_wrn;
  logic [2:0]  addr, cnt_sel, iack_lvl, ipln;
  logic [15:0] cpu_dout, cpu_din, q;
  logic [8:0]  cnt_dout;
  int          n_tests = 0;
  int          n_fail  = 0;

  jtcps2_irqctl #(.VB_LEVEL(3'd2), .RS_LEVEL(3'd4)) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .vb_start(vb_start), .raster(raster),
    .cs(cs), .addr(addr), .wrn(wrn), .cpu_dout(cpu_dout), .cnt_dout(cnt_dout),
    .cpu_din(cpu_din), .ok(ok), .cnt_sel(cnt_sel), .cnt_wrn(cnt_wrn),
    .iack(iack), .iack_lvl(iack_lvl), .ipln(ipln)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [2:0] a, input logic w, input logic [15:0] d,
                     output logic [15:0] rd);
    int unsigned n;
    cs = 1'b1; addr = a; wrn = w; cpu_dout = d; n = 0;
    do begin
      tick;
      n++;
    end while (ok !== 1'b1 && n < 8);
    check("bus_latency", 16'(n), 16'd3);
    rd = cpu_din;
    cs = 1'b0; wrn = 1'b1;
    tick;
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; vb_start = 1'b0; raster = 1'b0; cs = 1'b0;
    addr = '0; wrn = 1'b1; cpu_dout = '0; cnt_dout = 9'h1A5; iack = 1'b0; iack_lvl = '0;
    #23;
    check("rst_ipln", 16'(ipln), 16'h7);
    check("rst_cnt_wrn", 16'(cnt_wrn), 16'h1);
    check("rst_cnt_sel", 16'(cnt_sel), 16'h0);
    check("rst_ok", 16'(ok), 16'h0);
    check("rst_cpu_din", cpu_din, 16'h0);
    rst = 1'b0;
    tick;
    bus(3'd4, 1'b1, 16'h0, q); check("rst_status", q, 16'h0);
    bus(3'd5, 1'b1, 16'h0, q); check("unmapped_rd", q, 16'h0);

    // Counter write: strobes for two clocks, ok on the third, no retrigger while cs held
    cs = 1'b1; addr = 3'd1; wrn = 1'b0; cpu_dout = 16'h80F0;
    tick; check("cw1_sel", 16'(cnt_sel), 16'h2); check("cw1_wrn", 16'(cnt_wrn), 16'h0);
    check("cw1_ok", 16'(ok), 16'h0);
    tick; check("cw2_sel", 16'(cnt_sel), 16'h2); check("cw2_wrn", 16'(cnt_wrn), 16'h0);
    tick; check("cw3_ok", 16'(ok), 16'h1); check("cw3_sel", 16'(cnt_sel), 16'h0);
    check("cw3_wrn", 16'(cnt_wrn), 16'h1);
    tick; check("cw4_ok", 16'(ok), 16'h0);
    tick; check("cw5_ok", 16'(ok), 16'h0); check("cw5_sel", 16'(cnt_sel), 16'h0);
    cs = 1'b0; wrn = 1'b1;
    tick;

    bus(3'd2, 1'b1, 16'h0, q); check("cnt_rd", q, 16'h01A5);
    bus(3'd7, 1'b0, 16'h3, q);
    bus(3'd3, 1'b1, 16'h0, q); check("unmapped_wr", q, 16'h0);

    // VBlank interrupt
    bus(3'd3, 1'b0, 16'h1, q);
    vb_start = 1'b1; tick; vb_start = 1'b0;
    check("vb_lat1", 16'(ipln), 16'h7);
    tick; check("vb_ipln", 16'(ipln), 16'h5);
    iack = 1'b1; iack_lvl = 3'd2;
    tick; check("vb_ack1", 16'(ipln), 16'h5);
    tick; check("vb_ack2", 16'(ipln), 16'h7);
    iack = 1'b0; tick;

    // Priority
    bus(3'd3, 1'b0, 16'h3, q);
    vb_start = 1'b1; raster = 1'b1; tick; vb_start = 1'b0;
    tick; check("pri_rs", 16'(ipln), 16'h3);
    bus(3'd4, 1'b1, 16'h0, q); check("pri_status", q, 16'h3);
    iack = 1'b1; iack_lvl = 3'd4; tick; tick;
    check("pri_vb", 16'(ipln), 16'h5);
    iack = 1'b0; tick;
    iack = 1'b1; iack_lvl = 3'd3; tick; tick;
    check("ack_other_lvl", 16'(ipln), 16'h5);
    iack = 1'b0; tick;
    iack = 1'b1; iack_lvl = 3'd2; tick; tick;
    check("pri_none", 16'(ipln), 16'h7);
    iack = 1'b0; raster = 1'b0; tick;

    // Status-write clear colliding with raster rise
    cs = 1'b1; addr = 3'd4; wrn = 1'b0; cpu_dout = 16'h2;
    tick; tick; raster = 1'b1; tick;
    check("col_ok", 16'(ok), 16'h1);
    cs = 1'b0; wrn = 1'b1; tick;
    check("col_ipln", 16'(ipln), 16'h3);
    raster = 1'b0;
    bus(3'd4, 1'b1, 16'h0, q); check("col_status", q, 16'h2);
    bus(3'd4, 1'b0, 16'h2, q); check("col_clear", 16'(ipln), 16'h7);

    // iack clear colliding with raster rise
    iack = 1'b1; iack_lvl = 3'd4; raster = 1'b1; tick;
    iack = 1'b0; tick; check("ack_col", 16'(ipln), 16'h3);
    iack = 1'b1; tick; tick; check("ack_col_clr", 16'(ipln), 16'h7);
    iack = 1'b0; raster = 1'b0; tick;

    // Enable cleared in the same clk as the event
    cs = 1'b1; addr = 3'd3; wrn = 1'b0; cpu_dout = 16'h1;
    tick; tick; raster = 1'b1; tick;
    cs = 1'b0; wrn = 1'b1; tick; tick;
    check("dis_col_ipln", 16'(ipln), 16'h7);
    raster = 1'b0;
    bus(3'd4, 1'b1, 16'h0, q); check("dis_col_status", q, 16'h0);

    // Disabled events
    bus(3'd3, 1'b0, 16'h0, q);
    vb_start = 1'b1; raster = 1'b1; tick; vb_start = 1'b0; tick; tick;
    check("dis_ipln", 16'(ipln), 16'h7);
    raster = 1'b0;
    bus(3'd4, 1'b1, 16'h0, q); check("dis_status", q, 16'h0);

    // Raster held high: one set, ack clears it for good
    bus(3'd3, 1'b0, 16'h2, q);
    raster = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    check("held_ipln", 16'(ipln), 16'h3);
    iack = 1'b1; iack_lvl = 3'd4; tick; tick;
    check("held_ack", 16'(ipln), 16'h7);
    for (int i = 0; i < 5; i++) tick;
    check("held_stay", 16'(ipln), 16'h7);
    bus(3'd4, 1'b1, 16'h0, q); check("held_status", q, 16'h0);
    iack = 1'b0; raster = 1'b0; tick;

    // Reset in the middle of a counter write
    cs = 1'b1; addr = 3'd0; wrn = 1'b0; cpu_dout = 16'h0055;
    tick; check("mid_sel", 16'(cnt_sel), 16'h1); check("mid_wrn", 16'(cnt_wrn), 16'h0);
    #2 rst = 1'b1; #1;
    check("mid_rst_wrn", 16'(cnt_wrn), 16'h1);
    check("mid_rst_sel", 16'(cnt_sel), 16'h0);
    cs = 1'b0; wrn = 1'b1;
    tick; rst = 1'b0; tick;
    bus(3'd3, 1'b1, 16'h0, q); check("mid_rst_ctrl", q, 16'h0);
    check("mid_rst_ipln", 16'(ipln), 16'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
